// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder.
//
// Optional feature macro: SPI_FLASH_FAST_READ_EN adds the fast-read command (0x0B)
// and the DUMMY state to the state encoding. When the macro is undefined, that
// state does not exist.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
`ifdef SPI_FLASH_FAST_READ_EN
    StDummy,
`endif
    StData,
    StIgnore
  } state_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int unsigned DUMMY_CYCLES = 8;

  // Bit position inside a little-endian word: byte lane in [4:3], bit in [2:0].
  function automatic logic [4:0] word_bit_pos(input logic [1:0] lane, input logic [2:0] bit_idx);
    return {lane, bit_idx};
  endfunction

endpackage

// File: rtl/spi_flash_sync_edge.sv
// Multi-flop synchronizer followed by an edge-detect flop.
//
// Ports:
//   clk_i  - system clock
//   d_i    - asynchronous input
//   q_o    - synchronized level
//   rise_o - one-cycle pulse on a 0->1 change of the synchronized level
//   fall_o - one-cycle pulse on a 1->0 change of the synchronized level
//
// The flops have no reset, so the synchronized level is already valid when the
// system reset releases; the parent relies on that to see a chip-select that is
// held low across reset.
module spi_flash_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    sync_q <= {sync_q[Stages-2:0], d_i};
    prev_q <= sync_q[Stages-1];
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;
  assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash target (mode 0, MSB first) serving the read command 0x03 with a
// 24-bit address from a word-wide memory read port, with auto-increment and a
// one-word prefetch. SCK/SS/MOSI are oversampled on the system clock.
//
// Ports:
//   clock, reset       - system clock, synchronous active-low reset
//   spi_sck/ss/mosi    - SPI inputs from the master (asynchronous)
//   spi_miso           - SPI data out, idles high
//   mem_req, mem_addr  - one-cycle word fetch pulse and word address (byte addr[23:2])
//   mem_rdata/rvalid   - little-endian read word and its one-cycle strobe
//   busy               - state not idle while chip-select is low
//   err_underrun       - sticky: a data bit was due before its word arrived
//
// Optional feature macro: SPI_FLASH_FAST_READ_EN accepts command 0x0B, which adds
// eight dummy SCK cycles after the address; the fetch is issued at address
// completion so the dummy cycles hide memory latency.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              err_underrun
);

  localparam int unsigned MaxCount = (ADDR_W > DUMMY_CYCLES) ? ADDR_W : DUMMY_CYCLES;
  localparam int unsigned CntW     = $clog2(MaxCount);

  // Input synchronization
  logic sck_sync, sck_rise, sck_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_flash_sync_edge #(.Stages(SYNC_STAGES)) u_sync_sck (
    .clk_i  (clock),
    .d_i    (spi_sck),
    .q_o    (sck_sync),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_flash_sync_edge #(.Stages(SYNC_STAGES)) u_sync_ss (
    .clk_i  (clock),
    .d_i    (spi_ss),
    .q_o    (ss_sync),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_flash_sync_edge #(.Stages(SYNC_STAGES)) u_sync_mosi (
    .clk_i  (clock),
    .d_i    (spi_mosi),
    .q_o    (mosi_sync),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  assign unused_sync = ^{sck_sync, mosi_rise, mosi_fall};

  // State
  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] shreg_q, shreg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [31:0]       word_q, word_d;
  logic              word_vld_q, word_vld_d;
  logic [31:0]       hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic              out_q, out_d;
  logic              miso_q, miso_d;
  logic              req_q, req_d;
  logic [ADDR_W-3:0] req_addr_q, req_addr_d;
  logic              err_q, err_d;
  logic [31:0]       cur_word;
`ifdef SPI_FLASH_FAST_READ_EN
  logic              fast_q, fast_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    addr_d     = addr_q;
    bit_idx_d  = bit_idx_q;
    word_d     = word_q;
    word_vld_d = word_vld_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    out_d      = out_q;
    miso_d     = miso_q;
    req_d      = 1'b0;
    req_addr_d = req_addr_q;
    err_d      = err_q;
    cur_word   = word_vld_q ? word_q : hold_q;
`ifdef SPI_FLASH_FAST_READ_EN
    fast_d     = fast_q;
`endif

    // A response only counts when a request is outstanding.
    if (mem_rvalid && out_q) begin
      hold_d     = mem_rdata;
      hold_vld_d = 1'b1;
      out_d      = 1'b0;
    end

    if (ss_rise) begin
      // Deselect wins over any simultaneous SCK edge; partial bytes and late
      // responses are dropped.
      state_d    = StIdle;
      miso_d     = 1'b1;
      out_d      = 1'b0;
      hold_vld_d = 1'b0;
      word_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (ss_fall) begin
            state_d = StCmd;
          end else if (!ss_sync) begin
            // Chip-select already low (held across reset): wait for deselect.
            state_d = StIgnore;
          end
        end

        StCmd: begin
          if (sck_rise) begin
            shreg_d = {shreg_q[ADDR_W-2:0], mosi_sync};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntW'(7)) begin
              cnt_d = '0;
              if (shreg_d[7:0] == CMD_READ) begin
                state_d = StAddr;
`ifdef SPI_FLASH_FAST_READ_EN
                fast_d  = 1'b0;
              end else if (shreg_d[7:0] == CMD_FAST_READ) begin
                state_d = StAddr;
                fast_d  = 1'b1;
`else
              end else if (shreg_d[7:0] == CMD_FAST_READ) begin
                state_d = StIgnore;
`endif
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end

        StAddr: begin
          if (sck_rise) begin
            shreg_d = {shreg_q[ADDR_W-2:0], mosi_sync};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntW'(ADDR_W - 1)) begin
              cnt_d      = '0;
              addr_d     = shreg_d;
              bit_idx_d  = 3'd7;
              req_d      = 1'b1;
              req_addr_d = shreg_d[ADDR_W-1:2];
              out_d      = 1'b1;
              hold_vld_d = 1'b0;
              word_vld_d = 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
              state_d    = fast_q ? StDummy : StData;
`else
              state_d    = StData;
`endif
            end
          end
        end

`ifdef SPI_FLASH_FAST_READ_EN
        StDummy: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(DUMMY_CYCLES - 1)) begin
              cnt_d   = '0;
              state_d = StData;
            end
          end
        end
`endif

        StData: begin
          if (sck_fall) begin
            if (word_vld_q || hold_vld_q) begin
              if (!word_vld_q) begin
                // Current word exhausted: promote the prefetched word.
                word_d     = hold_q;
                word_vld_d = 1'b1;
                hold_vld_d = 1'b0;
              end
              miso_d = cur_word[word_bit_pos(addr_q[1:0], bit_idx_q)];
              // Last byte of the word starts now: fetch the following word.
              if (bit_idx_q == 3'd7 && addr_q[1:0] == 2'd3 && !out_q) begin
                req_d      = 1'b1;
                req_addr_d = addr_q[ADDR_W-1:2] + 1'b1;
                out_d      = 1'b1;
              end
              if (bit_idx_q == 3'd0) begin
                bit_idx_d = 3'd7;
                addr_d    = addr_q + 1'b1;
                if (addr_q[1:0] == 2'd3) begin
                  word_vld_d = 1'b0;
                end
              end else begin
                bit_idx_d = bit_idx_q - 1'b1;
              end
            end else begin
              // Underrun: the bit is not consumed, so streaming resumes at the
              // same position once the word lands.
              miso_d = 1'b1;
              err_d  = 1'b1;
            end
          end
        end

        StIgnore: begin
          miso_d = 1'b1;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shreg_q    <= '0;
      addr_q     <= '0;
      bit_idx_q  <= 3'd7;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      out_q      <= 1'b0;
      miso_q     <= 1'b1;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      err_q      <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      addr_q     <= addr_d;
      bit_idx_q  <= bit_idx_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      out_q      <= out_d;
      miso_q     <= miso_d;
      req_q      <= req_d;
      req_addr_q <= req_addr_d;
      err_q      <= err_d;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q     <= fast_d;
`endif
    end
  end

  assign spi_miso     = miso_q;
  assign mem_req      = req_q;
  assign mem_addr     = req_addr_q;
  assign err_underrun = err_q;
  assign busy         = (state_q != StIdle) && !ss_sync;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a cycle-driven SPI master, a small
// word memory with programmable latency, and immediate-assertion checks.
module tb_spi_flash_responder;

  localparam int Half = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        spi_sck;
  logic        spi_ss;
  logic        spi_mosi;
  logic        spi_miso;
  logic        mem_req;
  logic [21:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        busy;
  logic        err_underrun;

  int vectors     = 0;
  int miscompares = 0;
  int lat         = 2;
  int req_count   = 0;
  logic [21:0] req_log [0:7];

  spi_flash_responder #(
    .SYNC_STAGES (2),
    .ADDR_W      (24)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .spi_sck      (spi_sck),
    .spi_ss       (spi_ss),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .busy         (busy),
    .err_underrun (err_underrun)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [21:0] a);
    case (a)
      22'h000000: return 32'h44332211;
      22'h000001: return 32'h88776655;
      22'h000004: return 32'h0F0E0D0C;
      22'h3FFFFF: return 32'hDDCCBBAA;
      default:    return 32'hA5A5A5A5;
    endcase
  endfunction

  // Memory model: answers each request after lat cycles.
  initial begin
    logic [21:0] pend_addr;
    int          pend_cnt;
    pend_addr  = '0;
    pend_cnt   = 0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clock);
      mem_rvalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = word_of(pend_addr);
        end
      end
      if (mem_req) begin
        if (req_count < 8) req_log[req_count] = mem_addr;
        req_count = req_count + 1;
        pend_addr = mem_addr;
        pend_cnt  = lat;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_bits(input int n, input logic [7:0] tx, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      wait_clk(Half);
      spi_sck = 1'b1;
      rx = {rx[6:0], spi_miso};
      wait_clk(Half);
      spi_sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(8, tx, rx);
  endtask

  // Select, send command/address/dummies, collect nbytes little-endian.
  task automatic spi_read(input logic [7:0] cmd, input logic [23:0] a, input int ndummy,
                          input int nbytes, output logic [63:0] data);
    logic [7:0] r;
    data      = '0;
    req_count = 0;
    spi_ss    = 1'b0;
    wait_clk(Half);
    xfer(cmd, r);
    xfer(a[23:16], r);
    xfer(a[15:8], r);
    xfer(a[7:0], r);
    for (int i = 0; i < ndummy; i++) xfer(8'h00, r);
    for (int i = 0; i < nbytes; i++) begin
      xfer(8'hFF, r);
      data[8*i +: 8] = r;
    end
  endtask

  task automatic deselect();
    wait_clk(Half);
    spi_ss = 1'b1;
    wait_clk(4);
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  r0, r1, r2, r3;
    reset    = 1'b0;
    spi_sck  = 1'b0;
    spi_ss   = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(5);

    // Reset state
    chk("rst_miso", 64'(spi_miso), 64'h1);
    chk("rst_req", 64'(mem_req), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(err_underrun), 64'h0);
    reset = 1'b1;
    wait_clk(4);

    // Read @0, 4 bytes
    spi_read(8'h03, 24'h000000, 0, 4, d);
    chk("rd0_data", d, 64'h0000_0000_4433_2211);
    chk("rd0_busy", 64'(busy), 64'h1);
    chk("rd0_addr0", 64'(req_log[0]), 64'h0);
    deselect();
    chk("rd0_busy_after", 64'(busy), 64'h0);
    chk("rd0_err", 64'(err_underrun), 64'h0);
    wait_clk(4);

    // Read @2, 4 bytes crossing into word 1
    spi_read(8'h03, 24'h000002, 0, 4, d);
    chk("rd2_data", d, 64'h0000_0000_6655_4433);
    chk("rd2_reqs", 64'(req_count), 64'h2);
    chk("rd2_addr0", 64'(req_log[0]), 64'h0);
    chk("rd2_addr1", 64'(req_log[1]), 64'h1);
    deselect();
    wait_clk(4);

    // Read @FFFFFC, 8 bytes wrapping to word 0
    spi_read(8'h03, 24'hFFFFFC, 0, 8, d);
    chk("wrap_data", d, 64'h4433_2211_DDCC_BBAA);
    chk("wrap_addr0", 64'(req_log[0]), 64'h3FFFFF);
    chk("wrap_addr1", 64'(req_log[1]), 64'h0);
    deselect();
    wait_clk(4);

    // Unknown command 0x9F
    req_count = 0;
    spi_ss    = 1'b0;
    wait_clk(Half);
    xfer(8'h9F, r0);
    xfer(8'h00, r1);
    xfer(8'h00, r2);
    xfer(8'h00, r3);
    chk("bad_miso", 64'({r0, r1, r2, r3}), 64'hFFFF_FFFF);
    chk("bad_busy", 64'(busy), 64'h1);
    chk("bad_reqs", 64'(req_count), 64'h0);
    deselect();
    chk("bad_busy_after", 64'(busy), 64'h0);
    wait_clk(4);
    spi_read(8'h03, 24'h000000, 0, 4, d);
    chk("after_bad_data", d, 64'h0000_0000_4433_2211);
    deselect();
    wait_clk(4);

`ifdef SPI_FLASH_FAST_READ_EN
    spi_read(8'h0B, 24'h000010, 1, 4, d);
    chk("fast_data", d, 64'h0000_0000_0F0E_0D0C);
    chk("fast_addr0", 64'(req_log[0]), 64'h4);
`else
    spi_read(8'h0B, 24'h000010, 0, 4, d);
    chk("fast_off_data", d, 64'h0000_0000_FFFF_FFFF);
    chk("fast_off_reqs", 64'(req_count), 64'h0);
`endif
    deselect();
    chk("fast_err", 64'(err_underrun), 64'h0);
    wait_clk(4);

    // Abort after 12 address bits, then reset with SS held low
    req_count = 0;
    spi_ss    = 1'b0;
    wait_clk(Half);
    xfer(8'h03, r0);
    spi_bits(4, 8'h00, r1);
    xfer(8'h00, r1);
    deselect();
    chk("abort_reqs", 64'(req_count), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    spi_ss = 1'b0;
    reset  = 1'b0;
    wait_clk(4);
    chk("rst2_miso", 64'(spi_miso), 64'h1);
    chk("rst2_busy", 64'(busy), 64'h0);
    chk("rst2_req", 64'(mem_req), 64'h0);
    reset = 1'b1;
    wait_clk(4);
    chk("ign_busy", 64'(busy), 64'h1);
    req_count = 0;
    xfer(8'h03, r0);
    xfer(8'h00, r1);
    xfer(8'h00, r2);
    xfer(8'h00, r3);
    xfer(8'hFF, r3);
    chk("ign_miso", 64'({r0, r3}), 64'hFFFF);
    chk("ign_reqs", 64'(req_count), 64'h0);
    deselect();
    chk("ign_busy_after", 64'(busy), 64'h0);
    wait_clk(4);

    // Slow memory: first bits underrun
    lat = 60;
    spi_read(8'h03, 24'h000000, 0, 1, d);
    chk("under_miso_hi", 64'(d[7:4]), 64'hF);
    chk("under_err", 64'(err_underrun), 64'h1);
    deselect();
    wait_clk(80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI flash target for the flash chip-select of the SoC SPI master (mode 0, MSB first); the counterpart of the APB-to-SPI bridge that issues XIP reads.
- Decodes read command 0x03 plus a 24-bit address, then streams bytes on MISO from a word-wide memory read port with auto-increment.
- Oversamples SCK/SS/MOSI on the system clock; replaces the behavioural flash model in RTL-only and FPGA builds.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for sck/ss/mosi (≥2)
- ADDR_W, 24, byte-address width carried in the command

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- spi_sck  in  1  serial clock from master, asynchronous
- spi_ss  in  1  chip select, active low, asynchronous
- spi_mosi  in  1  master-out data
- spi_miso  out  1  slave-out data
- mem_req  out  1  one-cycle word fetch pulse
- mem_addr  out  22  word address (byte addr[23:2])
- mem_rdata  in  32  little-endian word; byte 0 = [7:0]
- mem_rvalid  in  1  one-cycle response strobe for the outstanding req
- busy  out  1  high while SS asserted and a transaction is being decoded or served
- err_underrun  out  1  sticky; set when a data bit is due before its word arrived

Behaviour:
- Reset (reset==0 at a clock edge): spi_miso=1, mem_req=0, mem_addr=0, busy=0, err_underrun=0, state=IDLE, outstanding flag cleared.
  - If synced SS is low when reset releases, go to IGNORE.
- Input path: SYNC_STAGES flops per input, then one edge-detect flop. rise/fall are single-cycle pulses of synced SCK.
- States:
  - IDLE: SS falling → CMD, bit counter=0.
  - CMD: shift MOSI on each rise. After 8 bits: 0x03 → ADDR; any other value → IGNORE.
  - ADDR: shift 24 bits on each rise. On the cycle after the 24th rise: latch addr, pulse mem_req with mem_addr=addr[23:2], go to DATA.
  - DATA: on each fall, drive the next bit on spi_miso.
    - Byte order within a word: addr[1:0] selects the starting byte; bytes go 0→3, each MSB first.
    - After bit 0 of a byte, addr increments by 1. Wrap 0xFFFFFF → 0x000000.
    - Prefetch: when the last byte of a word (addr[1:0]==3) starts shifting, pulse mem_req for the next word. At most one request outstanding.
    - Returned word goes into a 32-bit holding buffer, then into the shift word when the current word is exhausted.
    - Data not present when a bit is due: drive 1, set err_underrun, stay in DATA.
  - IGNORE: spi_miso=1, no fetches, until SS rises.
- SS rising in any state, including mid-byte or with a request outstanding → IDLE on the next cycle; spi_miso=1.
  - A late mem_rvalid is discarded.
  - A partial byte is dropped.
- mem_rvalid with nothing outstanding is ignored.
- Simultaneous SS rise and SCK edge: SS wins; the edge is ignored.
- Master timing contract: SCK half-period ≥ SYNC_STAGES + 3 + memory latency clocks. The first data bit is needed at the fall following the 32nd rise.
- busy = (state != IDLE) && synced SS low.

Optional Feature:
- Macro SPI_FLASH_FAST_READ_EN.
- Defined: command 0x0B is also accepted. It behaves like 0x03 but inserts a DUMMY state of 8 SCK cycles after the address; mem_req issues at address completion, so the dummy cycles hide fetch latency.
- Undefined: 0x0B → IGNORE, and no DUMMY state exists in the encoding.

Decomposition:
- Package spi_flash_pkg holds:
  - state enum {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE}
  - constants CMD_READ=8'h03, CMD_FAST_READ=8'h0B, DUMMY_CYCLES=8
- One sub-module: spi_flash_sync_edge, the synchronizer plus rise/fall detect. Instantiate it for SCK, and reuse its sync path for SS and MOSI.

Test Plan:
- Read 0x03 @0x000000, 4 bytes, mem word 0x44332211 → MISO bytes 11,22,33,44; master-side byte swap yields 0x44332211; err_underrun=0.
- Read @0x000002, 4 bytes, words 0x44332211 then 0x88776655 → bytes 33,44,55,66; exactly 2 mem_req, mem_addr 0 then 1.
- Read @0xFFFFFC, 8 bytes → second mem_addr=0x000000 (wrap); bytes continue from word 0.
- Command 0x9F → no mem_req, MISO=1 for 32 clocks, busy drops one cycle after SS rises; next 0x03 transaction succeeds.
- SS raised after 12 address bits; then reset pulsed low with SS held low → IDLE, no mem_req, MISO=1; after reset releases, the block stays in IGNORE until SS rises.
- Memory latency exceeding the half-period → err_underrun=1 and MISO=1 for the affected bits. With SPI_FLASH_FAST_READ_EN: 0x0B @0x10 yields the correct bytes with err_underrun=0.
